// File: rtl/lfsr_burst_arbiter.sv
// lfsr_burst_arbiter
//   Shares one external LFSR among NUM_REQ requesters. A grant delivers a
//   burst of BURST_LEN LFSR words over a valid/ready handshake, and the LFSR
//   enable is driven so the LFSR advances exactly once per accepted word.
//   Arbitration is strict round-robin with one idle bubble between bursts.
//
//   Optional feature macro: LFSR_ARB_TIMEOUT_EN
//     defined   : a burst stalled for TIMEOUT consecutive cycles is aborted
//                 with a one-cycle abort pulse.
//     undefined : abort is tied low and a stalled burst waits indefinitely.
module lfsr_burst_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 8,
  parameter int DATA_W    = 64,
  parameter int TIMEOUT   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  input  logic [NUM_REQ-1:0] rsp_ready,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_last,
  output logic               lfsr_en,
  input  logic [DATA_W-1:0]  lfsr_out,
  output logic               busy,
  output logic               abort
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  // Beat index that carries rsp_last.
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  // Grant vector for requester 0; shifted to build the one-hot grant.
  localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};
  // Highest requester index, used for the round-robin wrap.
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Registered state
  state_t             state_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic [PTR_W-1:0]   g_idx_r;     // index of the granted requester
  logic [PTR_W-1:0]   rr_ptr_r;    // search start for the next arbitration
  logic [CNT_W-1:0]   beat_cnt_r;  // words accepted in the current burst

  // Next-state values
  state_t             state_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [PTR_W-1:0]   g_idx_s;
  logic [PTR_W-1:0]   rr_ptr_s;
  logic [CNT_W-1:0]   beat_cnt_s;

  // Arbitration and handshake helpers
  logic               pick_found_s;
  logic [PTR_W-1:0]   pick_idx_s;
  logic [PTR_W:0]     cand_s;      // one extra bit so the wrap can be detected
  logic [PTR_W-1:0]   next_ptr_s;
  logic               hs_s;
  logic               abort_s;

  // A word is accepted when a burst is active and the granted requester is ready.
  assign hs_s = (state_r == ST_BURST) && rsp_ready[g_idx_r];

  // Round-robin successor of the current grant; becomes rr_ptr when the burst ends.
  always_comb begin
    next_ptr_s = '0;
    if (g_idx_r == LAST_REQ) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = g_idx_r + PTR_W'(1);
    end
  end

  // Find the first requesting index at or above rr_ptr, wrapping past NUM_REQ-1 to 0.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(i);
      if (cand_s >= (PTR_W+1)'(NUM_REQ)) begin
        cand_s = cand_s - (PTR_W+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!pick_found_s && req[cand_s[PTR_W-1:0]]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s[PTR_W-1:0];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

`ifdef LFSR_ARB_TIMEOUT_EN
  localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Stall count at which a further cycle without a handshake aborts the burst.
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  logic [STALL_W-1:0] stall_cnt_r;
  logic [STALL_W-1:0] stall_cnt_s;

  // Count consecutive stalled burst cycles and flag the abort on the last tolerated one.
  always_comb begin
    abort_s     = 1'b0;
    stall_cnt_s = '0;
    if (state_r == ST_BURST) begin
      if (hs_s) begin
        stall_cnt_s = '0;
      end else if (stall_cnt_r == STALL_LAST) begin
        abort_s     = 1'b1;
        stall_cnt_s = '0;
      end else begin
        stall_cnt_s = stall_cnt_r + STALL_W'(1);
      end
    end else begin
      stall_cnt_s = '0;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_r <= '0;
    end else begin
      stall_cnt_r <= stall_cnt_s;
    end
  end
`else
  // Without the timeout a stalled burst simply waits; TIMEOUT has no effect.
  assign abort_s = 1'b0;
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT > 0);
`endif

  // Next-state logic: arbitrate in IDLE, count accepted beats in BURST.
  always_comb begin
    state_s    = state_r;
    gnt_s      = gnt_r;
    g_idx_s    = g_idx_r;
    rr_ptr_s   = rr_ptr_r;
    beat_cnt_s = beat_cnt_r;
    case (state_r)
      ST_IDLE: begin
        beat_cnt_s = '0;
        if (pick_found_s) begin
          state_s = ST_BURST;
          gnt_s   = ONE_HOT_LSB << pick_idx_s;
          g_idx_s = pick_idx_s;
        end else begin
          gnt_s   = '0;
        end
      end
      ST_BURST: begin
        if (hs_s) begin
          if (beat_cnt_r == LAST_BEAT) begin
            // Final word accepted: release and hand priority to the next requester.
            state_s    = ST_IDLE;
            gnt_s      = '0;
            beat_cnt_s = '0;
            rr_ptr_s   = next_ptr_s;
          end else begin
            beat_cnt_s = beat_cnt_r + CNT_W'(1);
          end
        end else if (abort_s) begin
          // Timed out: drop the remaining words; consumed words stay consumed.
          state_s    = ST_IDLE;
          gnt_s      = '0;
          beat_cnt_s = '0;
          rr_ptr_s   = next_ptr_s;
        end else begin
          state_s    = ST_BURST;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        gnt_s      = '0;
        g_idx_s    = '0;
        rr_ptr_s   = '0;
        beat_cnt_s = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset; a reset mid-burst discards it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      gnt_r      <= '0;
      g_idx_r    <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      gnt_r      <= gnt_s;
      g_idx_r    <= g_idx_s;
      rr_ptr_r   <= rr_ptr_s;
      beat_cnt_r <= beat_cnt_s;
    end
  end

  // Outputs are decoded from registered state; lfsr_en and abort follow the
  // requester's ready in the same cycle so the LFSR steps once per accepted word.
  assign gnt       = gnt_r;
  assign rsp_valid = (state_r == ST_BURST);
  assign busy      = (state_r == ST_BURST);
  assign rsp_last  = (state_r == ST_BURST) && (beat_cnt_r == LAST_BEAT);
  assign lfsr_en   = hs_s;
  assign rsp_data  = lfsr_out;
  assign abort     = abort_s;

endmodule

// File: tb/tb_lfsr_burst_arbiter.sv
// Testbench for lfsr_burst_arbiter: an LFSR model supplies lfsr_out, the
// stimulus pushes expected words into a queue and a negedge monitor pops and
// compares each accepted word. Timeout checks run when LFSR_ARB_TIMEOUT_EN is set.
module tb_lfsr_burst_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int BURST_LEN = 8;
  localparam int DATA_W    = 64;
  localparam int TIMEOUT   = 16;
  localparam logic [63:0] SEED = 64'hACE1_2468_1357_BDF0;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [3:0]        req;
  logic [3:0]        gnt;
  logic [3:0]        rsp_ready;
  logic              rsp_valid;
  logic [63:0]       rsp_data;
  logic              rsp_last;
  logic              lfsr_en;
  logic [63:0]       lfsr_out;
  logic              busy;
  logic              abort;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0]  idx;
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];

  logic [63:0] lfsr_q   = SEED;  // external LFSR feeding the DUT
  logic [63:0] ref_lfsr = SEED;  // reference copy stepped once per expected word
  logic [63:0] w [0:8];

  lfsr_burst_arbiter #(
    .NUM_REQ(NUM_REQ), .BURST_LEN(BURST_LEN), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt), .rsp_ready(rsp_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .lfsr_en(lfsr_en), .lfsr_out(lfsr_out), .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  assign lfsr_out = lfsr_q;

  // External LFSR: advances only when the arbiter enables it.
  always @(posedge clk) begin
    if (lfsr_en === 1'b1) lfsr_q <= lfsr_step(lfsr_q);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input int idx, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.idx  = 2'(idx);
      e.data = ref_lfsr;
      e.last = (k == BURST_LEN - 1);
      exp_q.push_back(e);
      ref_lfsr = lfsr_step(ref_lfsr);
    end
  endtask

  // Monitor: on every accepted word, pop the expected entry and compare.
  always @(negedge clk) begin : mon
    exp_t       e;
    logic [3:0] oh;
    if (reset_n === 1'b1 && rsp_valid === 1'b1 && (gnt & rsp_ready) != 4'b0000) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL mon_unexpected_word: got data 0x%0h gnt 0x%0h, required no handshake at %0t",
                 rsp_data, gnt, $time);
      end else begin
        e  = exp_q.pop_front();
        oh = 4'b0001 << e.idx;
        check("mon_gnt", 64'(gnt), 64'(oh));
        check("mon_data", rsp_data, e.data);
        check("mon_last", 64'(rsp_last), 64'(e.last));
        check("mon_lfsr_en", 64'(lfsr_en), 64'd1);
      end
    end else if (reset_n === 1'b1 && rsp_valid === 1'b1) begin
      check("mon_stall_lfsr_en", 64'(lfsr_en), 64'd0);
    end
  end

  // Watchdog: the run must never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    reset_n   = 1'b0;
    req       = 4'hF;
    rsp_ready = 4'hF;

    // 1. Reset held with all requests pending
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_gnt", 64'(gnt), 64'd0);
      check("rst_valid", 64'(rsp_valid), 64'd0);
      check("rst_lfsr_en", 64'(lfsr_en), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_abort", 64'(abort), 64'd0);
    end
    reset_n = 1'b1;
    req     = 4'b0000;
    tick();

    // 2. Single requester 1, always ready; req dropped mid-burst is ignored
    req = 4'b0010;
    push_burst(1, 8);
    tick();
    check("t2_gnt", 64'(gnt), 64'h2);
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_valid", 64'(rsp_valid), 64'd1);
    req = 4'b0000;
    repeat (8) tick();
    check("t2_gnt_release", 64'(gnt), 64'd0);
    check("t2_busy_release", 64'(busy), 64'd0);

    // Re-reset so round-robin starts from requester 0; the LFSR keeps its state
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;

    // 3. Full contention: grants 0,1,2,3,0 with one bubble cycle between bursts
    req = 4'hF;
    for (int b = 0; b < 5; b++) begin
      push_burst(b % 4, 8);
      tick();
      check("t3_gnt", 64'(gnt), 64'(4'b0001 << (b % 4)));
      repeat (8) tick();
      if (b == 4) req = 4'b0000;
      check("t3_bubble_gnt", 64'(gnt), 64'd0);
      check("t3_bubble_valid", 64'(rsp_valid), 64'd0);
    end

    // 4. Backpressure on requester 0: ready 1,0,1,0,...
    w[0] = ref_lfsr;
    for (int i = 0; i < 8; i++) w[i+1] = lfsr_step(w[i]);
    req       = 4'b0001;
    rsp_ready = 4'b0001;
    push_burst(0, 8);
    tick();
    check("t4_gnt", 64'(gnt), 64'h1);
    req = 4'b0000;
    for (int c = 1; c < 15; c++) begin
      tick();
      rsp_ready = (c % 2 == 0) ? 4'b0001 : 4'b0000;
      #1;
      if (c % 2 == 1) begin
        check("t4_stall_data", rsp_data, w[(c + 1) / 2]);
        check("t4_stall_en", 64'(lfsr_en), 64'd0);
      end
    end
    tick();
    check("t4_gnt_release", 64'(gnt), 64'd0);

    // 5. Reset after three beats of requester 2
    rsp_ready = 4'hF;
    req       = 4'b0100;
    push_burst(2, 3);
    tick();
    check("t5_gnt", 64'(gnt), 64'h4);
    req = 4'b0000;
    tick();
    tick();
    tick();
    rsp_ready = 4'b0000;
    reset_n   = 1'b0;
    #1;
    check("t5_pre_rst_en", 64'(lfsr_en), 64'd0);
    tick();
    check("t5_rst_gnt", 64'(gnt), 64'd0);
    check("t5_rst_valid", 64'(rsp_valid), 64'd0);
    check("t5_rst_last", 64'(rsp_last), 64'd0);
    check("t5_rst_lfsr_en", 64'(lfsr_en), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_abort", 64'(abort), 64'd0);
    reset_n   = 1'b1;
    rsp_ready = 4'hF;
    req       = 4'hF;
    push_burst(0, 8);
    tick();
    check("t5_gnt_after_rst", 64'(gnt), 64'h1);
    req = 4'b0000;
    repeat (8) tick();
    check("t5_gnt_release", 64'(gnt), 64'd0);

`ifdef LFSR_ARB_TIMEOUT_EN
    // 6. Requester 1 never ready: abort in stall cycle 16, then requester 2
    rsp_ready = 4'b0000;
    req       = 4'b0110;
    tick();
    check("t6_gnt", 64'(gnt), 64'h2);
    for (int c = 1; c < 16; c++) begin
      check("t6_no_abort", 64'(abort), 64'd0);
      check("t6_no_en", 64'(lfsr_en), 64'd0);
      tick();
    end
    check("t6_abort", 64'(abort), 64'd1);
    check("t6_abort_en", 64'(lfsr_en), 64'd0);
    tick();
    check("t6_gnt_dropped", 64'(gnt), 64'd0);
    check("t6_abort_pulse_end", 64'(abort), 64'd0);
    rsp_ready = 4'hF;
    push_burst(2, 8);
    tick();
    check("t6_next_gnt", 64'(gnt), 64'h4);
    req = 4'b0000;
    repeat (8) tick();
    check("t6_gnt_release", 64'(gnt), 64'd0);
`endif

    // Drain: every expected word must have been seen
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
